// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: picks the highest-priority takeable interrupt from the
// CSR image and presents it to commit as a registered request. Once raised,
// the request holds a stable cause/target until it is accepted or withdrawn.
// After acceptance, new requests stay blocked for a few cycles so that the
// trap-entry CSR writes can settle.
module interrupt_arbiter #(
  parameter int XLEN     = 64,
  parameter int COOLDOWN = 2
) (
  input  logic            clk_i,
  input  logic            arst_n,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mip_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mideleg_i,
  input  logic [XLEN-1:0] dstatus_i,
  input  logic [1:0]      priv_i,
  input  logic            debug_mode_i,
  input  logic            flush_i,
  output logic            int_req_o,
  output logic [3:0]      int_cause_o,
  output logic            int_to_s_o,
  input  logic            int_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } state_t;

  // Standard interrupt positions: SSI, MSI, STI, MTI, SEI, MEI.
  localparam logic [11:0] INT_BITS = 12'hAAA;
  localparam logic [2:0]  CD_LOAD  = 3'(COOLDOWN - 1);

  state_t      state;
  logic [2:0]  cool_cnt;

  logic [11:0] pend;
  logic [11:0] m_grp;
  logic [11:0] s_grp;
  logic        m_take;
  logic        s_take;
  logic        mask;
  logic        cand_vld;
  logic [3:0]  cand_cause;
  logic        cand_to_s;
  logic        held_ok;
  logic        unused_bits;

  // Fixed priority within a group: MEI, MSI, MTI, SEI, SSI, STI.
  function automatic logic [3:0] pick_cause(input logic [11:0] v);
    logic [3:0] c;
    if (v[11])      c = 4'd11;
    else if (v[3])  c = 4'd3;
    else if (v[7])  c = 4'd7;
    else if (v[9])  c = 4'd9;
    else if (v[1])  c = 4'd1;
    else            c = 4'd5;
    return c;
  endfunction

  assign pend   = mip_i[11:0] & mie_i[11:0] & INT_BITS;
  // M-mode traps are globally enabled below M, or in M with MIE set.
  assign m_take = (priv_i != 2'd3) | mstatus_i[3];
  // S-mode traps are taken from U always, from S only with SIE, never from M.
  assign s_take = (priv_i == 2'd0) | ((priv_i == 2'd1) & mstatus_i[1]);
  assign m_grp  = pend & ~mideleg_i[11:0] & {12{m_take}};
  assign s_grp  = pend &  mideleg_i[11:0] & {12{s_take}};
  // Debug mode, a flush, or single-step without stepie suppresses everything.
  assign mask   = debug_mode_i | flush_i | (dstatus_i[2] & ~dstatus_i[11]);

  // Only bits [11:0] carry meaning; the rest of each CSR image is ignored.
  assign unused_bits = ^{mstatus_i, mip_i, mie_i, mideleg_i, dstatus_i};

  // Select the candidate: any takeable M-group interrupt beats the S-group.
  always_comb begin
    cand_vld   = 1'b0;
    cand_cause = 4'd0;
    cand_to_s  = 1'b0;
    if (!mask) begin
      if (|m_grp) begin
        cand_vld   = 1'b1;
        cand_cause = pick_cause(m_grp);
        cand_to_s  = 1'b0;
      end else if (|s_grp) begin
        cand_vld   = 1'b1;
        cand_cause = pick_cause(s_grp);
        cand_to_s  = 1'b1;
      end
    end
  end

  // The held request stays valid while its own cause is still takeable in its group.
  always_comb begin
    held_ok = 1'b0;
    if (!mask) begin
      held_ok = int_to_s_o ? s_grp[int_cause_o] : m_grp[int_cause_o];
    end
  end

  // Request FSM: raise, hold frozen until ack or withdraw, then cool down.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      int_req_o   <= 1'b0;
      int_cause_o <= 4'd0;
      int_to_s_o  <= 1'b0;
      cool_cnt    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_vld) begin
            state       <= REQ;
            int_req_o   <= 1'b1;
            int_cause_o <= cand_cause;
            int_to_s_o  <= cand_to_s;
          end
        end
        REQ: begin
          // Acceptance takes precedence over losing the candidate.
          if (int_ack_i) begin
            state     <= COOL;
            int_req_o <= 1'b0;
            cool_cnt  <= CD_LOAD;
          end else if (!held_ok) begin
            state     <= IDLE;
            int_req_o <= 1'b0;
          end
        end
        COOL: begin
          if (cool_cnt == 3'd0) begin
            state <= IDLE;
          end else begin
            cool_cnt <= cool_cnt - 3'd1;
          end
        end
        default: begin
          state     <= IDLE;
          int_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Bench for interrupt_arbiter: a table of single-cycle vectors, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_interrupt_arbiter;

  localparam int XLEN     = 64;
  localparam int COOLDOWN = 2;

  logic            clk_i = 1'b0;
  logic            arst_n;
  logic [XLEN-1:0] mstatus_i, mip_i, mie_i, mideleg_i, dstatus_i;
  logic [1:0]      priv_i;
  logic            debug_mode_i, flush_i, int_ack_i;
  logic            int_req_o;
  logic [3:0]      int_cause_o;
  logic            int_to_s_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit       m_req;
  bit [3:0] m_cause;
  bit       m_to_s;
  int       m_cool;

  interrupt_arbiter #(.XLEN(XLEN), .COOLDOWN(COOLDOWN)) dut (
    .clk_i       (clk_i),
    .arst_n      (arst_n),
    .mstatus_i   (mstatus_i),
    .mip_i       (mip_i),
    .mie_i       (mie_i),
    .mideleg_i   (mideleg_i),
    .dstatus_i   (dstatus_i),
    .priv_i      (priv_i),
    .debug_mode_i(debug_mode_i),
    .flush_i     (flush_i),
    .int_req_o   (int_req_o),
    .int_cause_o (int_cause_o),
    .int_to_s_o  (int_to_s_o),
    .int_ack_i   (int_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  priv;
    logic [63:0] mstatus;
    logic [63:0] mip;
    logic [63:0] mie;
    logic [63:0] mideleg;
    logic [63:0] dstatus;
    logic        dbg;
    logic        flush;
    logic        req;
    logic [3:0]  cause;
    logic        to_s;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: is interrupt bit b pending, enabled, of the requested group and takeable?
  function automatic bit bit_ok(int b, bit want_s);
    bit is_s, grp_take;
    if (b > 11 || (b % 2) == 0) return 0;
    if (!(mip_i[b] && mie_i[b])) return 0;
    is_s = mideleg_i[b];
    if (is_s != want_s) return 0;
    if (!is_s) grp_take = (priv_i != 2'd3) || mstatus_i[3];
    else       grp_take = (priv_i == 2'd0) || (priv_i == 2'd1 && mstatus_i[1]);
    return grp_take;
  endfunction

  function automatic bit masked();
    return debug_mode_i || flush_i || (dstatus_i[2] && !dstatus_i[11]);
  endfunction

  task automatic model_reset();
    m_req = 0; m_cause = 0; m_to_s = 0; m_cool = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int prio[6];
    bit found;
    prio = '{11, 3, 7, 9, 1, 5};
    if (m_req) begin
      if (int_ack_i) begin
        m_req = 0; m_cool = COOLDOWN;
      end else if (masked() || !bit_ok(int'(m_cause), m_to_s)) begin
        m_req = 0;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (!masked()) begin
      found = 0;
      for (int g = 0; g < 2 && !found; g++)
        for (int k = 0; k < 6 && !found; k++)
          if (bit_ok(prio[k], g[0])) begin
            found = 1; m_req = 1; m_cause = 4'(prio[k]); m_to_s = g[0];
          end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    chk("model_req", {63'd0, int_req_o}, {63'd0, m_req});
    chk("model_cause", {60'd0, int_cause_o}, {60'd0, m_cause});
    chk("model_to_s", {63'd0, int_to_s_o}, {63'd0, m_to_s});
  endtask

  // Async reset pulse placed between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req", {63'd0, int_req_o}, 64'd0);
    chk("rst_cause", {60'd0, int_cause_o}, 64'd0);
    #2 arst_n = 1'b1;
  endtask

  task automatic set_m(input logic [63:0] bits);
    priv_i = 2'd3; mstatus_i = 64'h8; mip_i = bits; mie_i = bits;
    mideleg_i = 0; dstatus_i = 0; debug_mode_i = 0; flush_i = 0; int_ack_i = 0;
  endtask

  initial begin
    arst_n = 1'b0;
    mstatus_i = 0; mip_i = 0; mie_i = 0; mideleg_i = 0; dstatus_i = 0;
    priv_i = 0; debug_mode_i = 0; flush_i = 0; int_ack_i = 0;
    model_reset();
    #1;
    chk("reset_req", {63'd0, int_req_o}, 64'd0);
    chk("reset_cause", {60'd0, int_cause_o}, 64'd0);
    chk("reset_to_s", {63'd0, int_to_s_o}, 64'd0);
    #2 arst_n = 1'b1;
    tick();

    // priv, mstatus, mip, mie, mideleg, dstatus, dbg, flush, req, cause, to_s
    vecs[0]  = '{2'd3, 64'h8, 64'h080, 64'h080, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 4'd7,  1'b0};
    vecs[1]  = '{2'd3, 64'h8, 64'h8A8, 64'h8A8, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 4'd11, 1'b0};
    vecs[2]  = '{2'd1, 64'h0, 64'h200, 64'h200, 64'h200, 64'h0,   1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    vecs[3]  = '{2'd0, 64'h0, 64'h200, 64'h200, 64'h200, 64'h0,   1'b0, 1'b0, 1'b1, 4'd9,  1'b1};
    vecs[4]  = '{2'd1, 64'h2, 64'h280, 64'h280, 64'h200, 64'h0,   1'b0, 1'b0, 1'b1, 4'd7,  1'b0};
    vecs[5]  = '{2'd3, 64'h8, 64'h800, 64'h800, 64'h0,   64'h4,   1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    vecs[6]  = '{2'd3, 64'h8, 64'h800, 64'h800, 64'h0,   64'h804, 1'b0, 1'b0, 1'b1, 4'd11, 1'b0};
    vecs[7]  = '{2'd3, 64'h0, 64'h080, 64'h080, 64'h0,   64'h0,   1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    vecs[8]  = '{2'd3, 64'hA, 64'h200, 64'h200, 64'h200, 64'h0,   1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    vecs[9]  = '{2'd1, 64'h0, 64'h008, 64'h008, 64'h0,   64'h0,   1'b0, 1'b0, 1'b1, 4'd3,  1'b0};
    vecs[10] = '{2'd0, 64'h0, 64'h222, 64'h222, 64'h222, 64'h0,   1'b0, 1'b0, 1'b1, 4'd9,  1'b1};
    vecs[11] = '{2'd0, 64'h0, 64'h022, 64'h022, 64'h022, 64'h0,   1'b0, 1'b0, 1'b1, 4'd1,  1'b1};
    vecs[12] = '{2'd3, 64'h8, 64'h800, 64'h800, 64'h0,   64'h0,   1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    vecs[13] = '{2'd3, 64'h8, 64'h800, 64'h800, 64'h0,   64'h0,   1'b1, 1'b0, 1'b0, 4'd0,  1'b0};
    vecs[14] = '{2'd3, 64'h8, 64'h400, 64'h400, 64'h0,   64'h0,   1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    vecs[15] = '{2'd3, 64'h8, 64'hFFFFFFFFFFFFF555, 64'hFFFFFFFFFFFFF555, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[16] = '{2'd1, 64'h2, 64'h022, 64'h022, 64'h022, 64'h0,   1'b0, 1'b0, 1'b1, 4'd1,  1'b1};
    vecs[17] = '{2'd1, 64'h0, 64'h02A, 64'h02A, 64'h022, 64'h0,   1'b0, 1'b0, 1'b1, 4'd3,  1'b0};

    for (int i = 0; i < 18; i++) begin
      pulse_reset();
      priv_i = vecs[i].priv; mstatus_i = vecs[i].mstatus; mip_i = vecs[i].mip;
      mie_i = vecs[i].mie; mideleg_i = vecs[i].mideleg; dstatus_i = vecs[i].dstatus;
      debug_mode_i = vecs[i].dbg; flush_i = vecs[i].flush; int_ack_i = 0;
      tick();
      chk($sformatf("vec%0d_req", i), {63'd0, int_req_o}, {63'd0, vecs[i].req});
      chk($sformatf("vec%0d_cause", i), {60'd0, int_cause_o}, {60'd0, vecs[i].cause});
      chk($sformatf("vec%0d_to_s", i), {63'd0, int_to_s_o}, {63'd0, vecs[i].to_s});
    end

    // Held request stays frozen; ack then cooldown before the next request.
    pulse_reset();
    set_m(64'h80);
    tick();
    chk("hold_first_req", {63'd0, int_req_o}, 64'd1);
    repeat (5) tick();
    mip_i = 64'h880; mie_i = 64'h880;
    tick(); tick();
    chk("hold_req", {63'd0, int_req_o}, 64'd1);
    chk("hold_cause", {60'd0, int_cause_o}, 64'd7);
    int_ack_i = 1; tick(); int_ack_i = 0;
    chk("ack_drop", {63'd0, int_req_o}, 64'd0);
    tick(); chk("cool1", {63'd0, int_req_o}, 64'd0);
    tick(); chk("cool2", {63'd0, int_req_o}, 64'd0);
    tick();
    chk("after_cool_req", {63'd0, int_req_o}, 64'd1);
    chk("after_cool_cause", {60'd0, int_cause_o}, 64'd11);

    // Withdraw goes to IDLE (immediate re-request); ack+loss goes to COOL.
    pulse_reset();
    set_m(64'h80);
    tick();
    mip_i = 0; tick();
    chk("withdraw", {63'd0, int_req_o}, 64'd0);
    chk("withdraw_cause_kept", {60'd0, int_cause_o}, 64'd7);
    mip_i = 64'h80; tick();
    chk("rereq_idle", {63'd0, int_req_o}, 64'd1);
    mip_i = 0; int_ack_i = 1; tick(); int_ack_i = 0;
    chk("ack_beats_withdraw", {63'd0, int_req_o}, 64'd0);
    mip_i = 64'h80;
    tick(); chk("ackw_cool1", {63'd0, int_req_o}, 64'd0);
    tick(); chk("ackw_cool2", {63'd0, int_req_o}, 64'd0);
    tick(); chk("ackw_rereq", {63'd0, int_req_o}, 64'd1);

    // Single-step masking, then debug mode withdraws a held request.
    pulse_reset();
    set_m(64'h800); dstatus_i = 64'h4;
    tick(); chk("step_masked", {63'd0, int_req_o}, 64'd0);
    dstatus_i = 64'h804;
    tick(); chk("stepie_req", {63'd0, int_req_o}, 64'd1);
    chk("stepie_cause", {60'd0, int_cause_o}, 64'd11);
    debug_mode_i = 1;
    tick(); chk("debug_withdraw", {63'd0, int_req_o}, 64'd0);
    debug_mode_i = 0;
    tick(); chk("debug_release", {63'd0, int_req_o}, 64'd1);

    // Ack outside REQ does nothing.
    pulse_reset();
    set_m(64'h0); int_ack_i = 1;
    tick(); tick();
    int_ack_i = 0; mip_i = 64'h8; mie_i = 64'h8;
    tick();
    chk("idle_ack_ignored", {63'd0, int_req_o}, 64'd1);
    chk("idle_ack_cause", {60'd0, int_cause_o}, 64'd3);

    // Async reset mid-REQ, held across an edge, then release.
    pulse_reset();
    set_m(64'h80);
    tick();
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_req_now", {63'd0, int_req_o}, 64'd0);
    @(posedge clk_i); #1;
    chk("arst_held", {63'd0, int_req_o}, 64'd0);
    #2 arst_n = 1'b1;
    tick();
    chk("arst_rereq", {63'd0, int_req_o}, 64'd1);
    chk("arst_rereq_cause", {60'd0, int_cause_o}, 64'd7);

    // Randomized run against the model.
    pulse_reset();
    set_m(64'h0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) mip_i = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) mie_i = $urandom_range(0, 1) ? '1 : {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) mideleg_i = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) mstatus_i = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) priv_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) dstatus_i = {$urandom, $urandom};
      debug_mode_i = ($urandom_range(0, 19) == 0);
      flush_i      = ($urandom_range(0, 19) == 0);
      int_ack_i    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
